wb_commit: RTL and testbench

- Writeback/commit end of the decode-stage register-file write interface. Drives writeflag, writetarget, aluwriteval, readoutwriteval and readoutSelect into the decode stage.
- Also tracks in-flight register destinations between issue and writeback. Exports a busy mask and a stall to decode.
- Sequences halt: drains all pending writes, then asserts haltout.

---
 rtl/wb_commit.sv | 204 ++++++++++++++++++++
 tb/tb_wb_commit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// Writeback/commit stage: registers results toward the decode-stage register file,
// tracks in-flight destinations per register, and sequences the halt drain.
module wb_commit #(
    parameter int MAXPEND = 3,
    parameter int CNTW    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_writereg,
    input  logic [2:0]  issue_regaddress,
    input  logic        issue_halt,
    input  logic        wb_valid,
    input  logic        wb_writereg,
    input  logic [2:0]  wb_regaddress,
    input  logic        wb_readoutSelect,
    input  logic [15:0] wb_aluval,
    input  logic [15:0] wb_readoutval,
    output logic        writeflag,
    output logic [2:0]  writetarget,
    output logic [15:0] aluwriteval,
    output logic [15:0] readoutwriteval,
    output logic        readoutSelect,
    output logic [7:0]  busymask,
    output logic        stall,
    output logic        haltout,
    output logic [15:0] retired,
    output logic        err
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(MAXPEND);

    state_t state_p1;
    state_t state_nxt;

    logic [7:0][CNTW-1:0] cnt_p1;
    logic [7:0][CNTW-1:0] cnt_nxt;
    logic [7:0]           inc_vec;
    logic [7:0]           dec_vec;
    logic [7:0]           underflow_vec;
    logic [7:0]           full_vec;

    logic                 accept;
    logic                 all_idle;
    logic                 dec_pending;
    logic                 drain_done;
    logic                 not_run;
    logic                 err_p1;

    logic                 writeflag_p1;
    logic [2:0]           writetarget_p1;
    logic [15:0]          aluwriteval_p1;
    logic [15:0]          readoutwriteval_p1;
    logic                 readoutselect_p1;
    logic [15:0]          retired_p1;

    // Counter next value: an increment and decrement together cancel, and a
    // lone decrement at zero holds zero (the caller flags it as an error).
    function automatic logic [CNTW-1:0] cnt_step(
        input logic [CNTW-1:0] cur,
        input logic            inc,
        input logic            dec
    );
        logic [CNTW-1:0] res;
        res = cur;
        if (inc && !dec) begin
            res = cur + CNTW'(1);
        end else if (dec && !inc && (cur != '0)) begin
            res = cur - CNTW'(1);
        end
        return res;
    endfunction

    function automatic logic cnt_underflow(
        input logic [CNTW-1:0] cur,
        input logic            inc,
        input logic            dec
    );
        return dec && !inc && (cur == '0);
    endfunction

    // Stage p0: issue/writeback decode against the registered scoreboard
    assign accept      = issue_valid & ~stall;
    assign dec_pending = wb_valid & wb_writereg;

    always_comb begin
        inc_vec       = '0;
        dec_vec       = '0;
        underflow_vec = '0;
        full_vec      = '0;
        cnt_nxt       = cnt_p1;
        for (int r = 0; r < 8; r++) begin
            inc_vec[r]       = accept & issue_writereg & ~issue_halt &
                               (issue_regaddress == 3'(r));
            dec_vec[r]       = dec_pending & (wb_regaddress == 3'(r));
            cnt_nxt[r]       = cnt_step(cnt_p1[r], inc_vec[r], dec_vec[r]);
            underflow_vec[r] = cnt_underflow(cnt_p1[r], inc_vec[r], dec_vec[r]);
            full_vec[r]      = (cnt_p1[r] == CNT_FULL);
        end
    end

    always_comb begin
        busymask = '0;
        all_idle = 1'b1;
        for (int r = 0; r < 8; r++) begin
            busymask[r] = (cnt_p1[r] != '0);
            if (cnt_p1[r] != '0) begin
                all_idle = 1'b0;
            end
        end
    end

    // The drain completes only once counters were already zero before this
    // edge; counters hitting zero on the edge itself defer halting by a cycle.
    assign drain_done = all_idle & ~dec_pending;
    assign stall      = not_run | (|full_vec);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_p1 <= RUN;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            RUN: begin
                if (accept && issue_halt) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        not_run = 1'b1;
        haltout = 1'b0;
        case (state_p1)
            RUN:     not_run = 1'b0;
            DRAIN:   not_run = 1'b1;
            HALTED:  haltout = 1'b1;
            default: not_run = 1'b1;
        endcase
    end

    // Stage p1: registered scoreboard, error flag and writeback outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_p1 <= '0;
            err_p1 <= 1'b0;
        end else begin
            cnt_p1 <= cnt_nxt;
            err_p1 <= err_p1 | (|underflow_vec);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            writeflag_p1       <= 1'b0;
            writetarget_p1     <= '0;
            aluwriteval_p1     <= '0;
            readoutwriteval_p1 <= '0;
            readoutselect_p1   <= 1'b0;
            retired_p1         <= '0;
        end else if (wb_valid) begin
            writeflag_p1       <= wb_writereg;
            writetarget_p1     <= wb_regaddress;
            aluwriteval_p1     <= wb_aluval;
            readoutwriteval_p1 <= wb_readoutval;
            readoutselect_p1   <= wb_readoutSelect;
            retired_p1         <= retired_p1 + 16'd1;
        end else begin
            writeflag_p1       <= 1'b0;
        end
    end

    assign writeflag       = writeflag_p1;
    assign writetarget     = writetarget_p1;
    assign aluwriteval     = aluwriteval_p1;
    assign readoutwriteval = readoutwriteval_p1;
    assign readoutSelect   = readoutselect_p1;
    assign retired         = retired_p1;
    assign err             = err_p1;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: a behavioural scoreboard model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_wb_commit;

    localparam int MAXPEND = 3;
    localparam int CNTW    = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_writereg = 1'b0;
    logic [2:0]  issue_regaddress = '0;
    logic        issue_halt = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_writereg = 1'b0;
    logic [2:0]  wb_regaddress = '0;
    logic        wb_readoutSelect = 1'b0;
    logic [15:0] wb_aluval = '0;
    logic [15:0] wb_readoutval = '0;
    logic        writeflag;
    logic [2:0]  writetarget;
    logic [15:0] aluwriteval;
    logic [15:0] readoutwriteval;
    logic        readoutSelect;
    logic [7:0]  busymask;
    logic        stall;
    logic        haltout;
    logic [15:0] retired;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    wb_commit #(.MAXPEND(MAXPEND), .CNTW(CNTW)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_writereg(issue_writereg),
        .issue_regaddress(issue_regaddress), .issue_halt(issue_halt),
        .wb_valid(wb_valid), .wb_writereg(wb_writereg),
        .wb_regaddress(wb_regaddress), .wb_readoutSelect(wb_readoutSelect),
        .wb_aluval(wb_aluval), .wb_readoutval(wb_readoutval),
        .writeflag(writeflag), .writetarget(writetarget),
        .aluwriteval(aluwriteval), .readoutwriteval(readoutwriteval),
        .readoutSelect(readoutSelect), .busymask(busymask), .stall(stall),
        .haltout(haltout), .retired(retired), .err(err)
    );

    always #5 clock = ~clock;

    // Behavioural model: pending counts as plain integers, halt progress as a
    // small phase number (0 running, 1 draining, 2 halted).
    int          m_cnt [8];
    int          m_phase = 0;
    bit          m_wf = 0;
    int          m_wt = 0;
    int          m_alu = 0;
    int          m_ro = 0;
    bit          m_sel = 0;
    int          m_retired = 0;
    bit          m_err = 0;
    bit          m_acc;
    bit          m_inc;
    bit          m_dec;

    function automatic bit m_stall();
        bit s;
        s = (m_phase != 0);
        for (int r = 0; r < 8; r++) if (m_cnt[r] == MAXPEND) s = 1'b1;
        return s;
    endfunction

    function automatic int m_busy();
        int b;
        b = 0;
        for (int r = 0; r < 8; r++) if (m_cnt[r] != 0) b = b | (1 << r);
        return b;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 8; r++) m_cnt[r] = 0;
            m_phase = 0; m_wf = 0; m_wt = 0; m_alu = 0; m_ro = 0;
            m_sel = 0; m_retired = 0; m_err = 0;
        end else begin
            m_acc = issue_valid && !m_stall();
            if (m_phase == 1 && m_busy() == 0 && !(wb_valid && wb_writereg))
                m_phase = 2;
            else if (m_phase == 0 && m_acc && issue_halt)
                m_phase = 1;
            for (int r = 0; r < 8; r++) begin
                m_inc = m_acc && issue_writereg && !issue_halt && (int'(issue_regaddress) == r);
                m_dec = wb_valid && wb_writereg && (int'(wb_regaddress) == r);
                if (m_inc && !m_dec) m_cnt[r] = m_cnt[r] + 1;
                else if (m_dec && !m_inc) begin
                    if (m_cnt[r] == 0) m_err = 1;
                    else m_cnt[r] = m_cnt[r] - 1;
                end
            end
            if (wb_valid) begin
                m_wf = wb_writereg; m_wt = int'(wb_regaddress);
                m_alu = int'(wb_aluval); m_ro = int'(wb_readoutval);
                m_sel = wb_readoutSelect;
                m_retired = (m_retired + 1) % 65536;
            end else begin
                m_wf = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("writeflag", 32'(writeflag), 32'(m_wf));
            chk("writetarget", 32'(writetarget), 32'(m_wt));
            chk("aluwriteval", 32'(aluwriteval), 32'(m_alu));
            chk("readoutwriteval", 32'(readoutwriteval), 32'(m_ro));
            chk("readoutSelect", 32'(readoutSelect), 32'(m_sel));
            chk("busymask", 32'(busymask), 32'(m_busy()));
            chk("stall", 32'(stall), 32'(m_stall()));
            chk("haltout", 32'(haltout), 32'(m_phase == 2));
            chk("retired", 32'(retired), 32'(m_retired));
            chk("err", 32'(err), 32'(m_err));
        end
    end

    task automatic set_issue(input bit v, input bit wr, input logic [2:0] a, input bit h);
        issue_valid = v; issue_writereg = wr; issue_regaddress = a; issue_halt = h;
    endtask

    task automatic set_wb(input bit v, input bit wr, input logic [2:0] a, input bit sel,
                          input logic [15:0] alu, input logic [15:0] ro);
        wb_valid = v; wb_writereg = wr; wb_regaddress = a;
        wb_readoutSelect = sel; wb_aluval = alu; wb_readoutval = ro;
    endtask

    task automatic clr();
        set_issue(0, 0, 3'd0, 0);
        set_wb(0, 0, 3'd0, 0, 16'h0, 16'h0);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        clr();
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        clr();
        #2 reset = 1'b0;
        #1 chk_en = 1'b1;
        tick();
        reset = 1'b1;

        // Reset then idle
        repeat (5) tick();
        chk("idle_writeflag", 32'(writeflag), 32'd0);
        chk("idle_busymask", 32'(busymask), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_haltout", 32'(haltout), 32'd0);
        chk("idle_retired", 32'(retired), 32'd0);
        chk("idle_alu", 32'(aluwriteval), 32'd0);

        // Single writeback
        set_wb(1, 1, 3'd5, 0, 16'h1234, 16'h0);
        tick(); clr();
        chk("wb1_writeflag", 32'(writeflag), 32'd1);
        chk("wb1_target", 32'(writetarget), 32'd5);
        chk("wb1_alu", 32'(aluwriteval), 32'h1234);
        chk("wb1_sel", 32'(readoutSelect), 32'd0);
        chk("wb1_retired", 32'(retired), 32'd1);
        tick();
        chk("wb1_flag_drop", 32'(writeflag), 32'd0);
        chk("wb1_alu_hold", 32'(aluwriteval), 32'h1234);

        // Scoreboard saturation on r2
        do_reset();
        set_issue(1, 1, 3'd2, 0);
        repeat (3) tick();
        chk("sat_busy", 32'(busymask), 32'h04);
        chk("sat_stall", 32'(stall), 32'd1);
        tick();
        chk("sat_4th_busy", 32'(busymask), 32'h04);
        chk("sat_4th_stall", 32'(stall), 32'd1);
        set_wb(1, 1, 3'd2, 0, 16'h0002, 16'h0);
        tick(); clr();
        chk("sat_wb_stall", 32'(stall), 32'd0);
        chk("sat_wb_busy", 32'(busymask), 32'h04);

        // Simultaneous issue and writeback on r3; underflow on r6
        do_reset();
        set_issue(1, 1, 3'd3, 0);
        tick();
        set_wb(1, 1, 3'd3, 1, 16'h0, 16'h5555);
        tick(); clr();
        chk("simul_busy", 32'(busymask), 32'h08);
        chk("simul_err", 32'(err), 32'd0);
        set_wb(1, 1, 3'd6, 0, 16'h6666, 16'h0);
        tick(); clr();
        chk("under_err", 32'(err), 32'd1);
        chk("under_busy6", 32'(busymask[6]), 32'd0);
        tick();
        chk("under_err_sticky", 32'(err), 32'd1);

        // Halt drain
        do_reset();
        set_issue(1, 1, 3'd1, 0); tick();
        set_issue(1, 1, 3'd4, 0); tick();
        set_issue(1, 0, 3'd0, 1); tick(); clr();
        chk("drain_stall", 32'(stall), 32'd1);
        chk("drain_halt0", 32'(haltout), 32'd0);
        chk("drain_busy", 32'(busymask), 32'h12);
        set_wb(1, 1, 3'd1, 0, 16'h0011, 16'h0); tick(); clr();
        chk("drain_after_r1", 32'(haltout), 32'd0);
        set_wb(1, 1, 3'd4, 0, 16'h0044, 16'h0); tick(); clr();
        chk("drain_r4_edge", 32'(haltout), 32'd0);
        tick();
        chk("drain_halted", 32'(haltout), 32'd1);
        chk("drain_halted_stall", 32'(stall), 32'd1);
        set_issue(1, 1, 3'd0, 0); tick(); clr();
        chk("halted_issue_ignored", 32'(busymask), 32'd0);
        set_wb(1, 0, 3'd7, 1, 16'h0, 16'hABCD); tick(); clr();
        chk("halted_wb_ro", 32'(readoutwriteval), 32'hABCD);
        chk("halted_wb_sel", 32'(readoutSelect), 32'd1);
        chk("halted_wb_retired", 32'(retired), 32'd3);
        chk("halted_still", 32'(haltout), 32'd1);

        // Halt with nothing pending; writereg ignored on a halt
        do_reset();
        set_issue(1, 1, 3'd5, 1); tick(); clr();
        chk("qhalt_edge1_halt", 32'(haltout), 32'd0);
        chk("qhalt_edge1_busy", 32'(busymask), 32'd0);
        chk("qhalt_edge1_stall", 32'(stall), 32'd1);
        tick();
        chk("qhalt_edge2_halt", 32'(haltout), 32'd1);

        // Retired wrap
        do_reset();
        set_wb(1, 0, 3'd0, 0, 16'h0, 16'h0);
        repeat (65535) tick();
        chk("wrap_ffff", 32'(retired), 32'hFFFF);
        tick(); clr();
        chk("wrap_zero", 32'(retired), 32'd0);

        // Asynchronous reset mid-cycle with state present
        set_issue(1, 1, 3'd1, 0); tick();
        set_issue(1, 1, 3'd2, 0);
        set_wb(1, 1, 3'd1, 0, 16'hBEEF, 16'hCAFE);
        tick(); clr();
        chk("pre_rst_flag", 32'(writeflag), 32'd1);
        chk("pre_rst_busy", 32'(busymask), 32'h04);
        #1 reset = 1'b0;
        #1;
        chk("async_writeflag", 32'(writeflag), 32'd0);
        chk("async_alu", 32'(aluwriteval), 32'd0);
        chk("async_ro", 32'(readoutwriteval), 32'd0);
        chk("async_busy", 32'(busymask), 32'd0);
        chk("async_retired", 32'(retired), 32'd0);
        chk("async_stall", 32'(stall), 32'd0);
        tick();
        reset = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
